// File: rtl/bypass_net.sv
// Decode-stage forwarding network: picks the youngest matching, ready producer per
// read port, registers the select/data for execute, and requests a load-use stall.
module bypass_net #(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_STAGES = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STALL_BIT  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [5:0]                     stall,
  input  logic [NUM_RPORTS-1:0]          rd_en,
  input  logic [NUM_RPORTS*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_STAGES-1:0]          st_we,
  input  logic [NUM_STAGES-1:0]          st_rdy,
  input  logic [NUM_STAGES*ADDR_W-1:0]   st_waddr,
  input  logic [NUM_STAGES*DATA_W-1:0]   st_wdata,
  output logic [NUM_RPORTS-1:0]          fwd_sel_r,
  output logic [NUM_RPORTS*DATA_W-1:0]   fwd_data_r,
  output logic                           stall_req
);

  logic [NUM_RPORTS-1:0]        w_found;
  logic [NUM_RPORTS-1:0]        w_fwd_vld;
  logic [NUM_RPORTS-1:0]        w_pend;
  logic [NUM_RPORTS*DATA_W-1:0] w_fwd_data;
  logic                         w_stall;
  logic                         w_unused_stall;

  logic [NUM_RPORTS-1:0]        r_sel;
  logic [NUM_RPORTS*DATA_W-1:0] r_data;

  assign w_stall        = stall[STALL_BIT];
  assign w_unused_stall = ^stall;

  // Scanning from stage 0 upward, the first hit is the youngest producer and
  // decides the port alone: a not-ready youngest hit masks any older ready one.
  always_comb begin
    // NOTE: every combinational output gets a default before the loops so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    w_found    = '0;
    w_fwd_vld  = '0;
    w_pend     = '0;
    w_fwd_data = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (!w_found[p] && rd_en[p] && st_we[s] &&
            (rd_addr[p*ADDR_W +: ADDR_W] == st_waddr[s*ADDR_W +: ADDR_W]) &&
            (rd_addr[p*ADDR_W +: ADDR_W] != '0)) begin
          w_found[p] = 1'b1;
          if (st_rdy[s]) begin
            w_fwd_vld[p]                  = 1'b1;
            w_fwd_data[p*DATA_W +: DATA_W] = st_wdata[s*DATA_W +: DATA_W];
          end else begin
            w_pend[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_req = |w_pend;

  // NOTE: state registers use non-blocking assignments so every port samples
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel  <= '0;
      r_data <= '0;
    end else begin
      for (int p = 0; p < NUM_RPORTS; p++) begin
        if (flush) begin
          r_sel[p]                   <= 1'b0;
          r_data[p*DATA_W +: DATA_W] <= '0;
        end else if (w_fwd_vld[p]) begin
          r_sel[p]                   <= 1'b1;
          r_data[p*DATA_W +: DATA_W] <= w_fwd_data[p*DATA_W +: DATA_W];
        end else if (w_pend[p]) begin
          // Data is left untouched while a load is outstanding.
          if (!w_stall) r_sel[p] <= 1'b0;
        end else if (!w_stall) begin
          r_sel[p]                   <= 1'b0;
          r_data[p*DATA_W +: DATA_W] <= '0;
        end
        // No hit under stall: hold, so a producer that retired is not lost.
      end
    end
  end

  assign fwd_sel_r  = r_sel;
  assign fwd_data_r = r_data;

endmodule

// File: tb/tb_bypass_net.sv
// Directed self-checking bench for bypass_net: default 2x3 instance plus a 4x4
// instance for per-port priority.
module tb_bypass_net;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;

  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [2:0]  st_we;
  logic [2:0]  st_rdy;
  logic [14:0] st_waddr;
  logic [95:0] st_wdata;
  logic [1:0]  fwd_sel_r;
  logic [63:0] fwd_data_r;
  logic        stall_req;

  logic [3:0]   b_rd_en;
  logic [19:0]  b_rd_addr;
  logic [3:0]   b_st_we;
  logic [3:0]   b_st_rdy;
  logic [19:0]  b_st_waddr;
  logic [127:0] b_st_wdata;
  logic [3:0]   b_sel;
  logic [127:0] b_data;
  logic         b_stall_req;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bypass_net u_dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .st_we(st_we), .st_rdy(st_rdy), .st_waddr(st_waddr), .st_wdata(st_wdata),
    .fwd_sel_r(fwd_sel_r), .fwd_data_r(fwd_data_r), .stall_req(stall_req)
  );

  bypass_net #(.NUM_RPORTS(4), .NUM_STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .st_we(b_st_we), .st_rdy(b_st_rdy), .st_waddr(b_st_waddr), .st_wdata(b_st_wdata),
    .fwd_sel_r(b_sel), .fwd_data_r(b_data), .stall_req(b_stall_req)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input int s, input logic we, input logic rdy,
                        input logic [4:0] a, input logic [31:0] d);
    st_we[s]           = we;
    st_rdy[s]          = rdy;
    st_waddr[s*5 +: 5] = a;
    st_wdata[s*32 +: 32] = d;
  endtask

  task automatic clear_st();
    st_we = '0; st_rdy = '0; st_waddr = '0; st_wdata = '0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    b_rd_en = '0; b_rd_addr = '0; b_st_we = '0; b_st_rdy = '0;
    b_st_waddr = '0; b_st_wdata = '0;

    // Reset held with live hits on the inputs.
    rd_en = 2'b11; rd_addr = {5'd6, 5'd6};
    clear_st();
    set_st(0, 1'b1, 1'b1, 5'd6, 32'hCAFE_F00D);
    step(); step();
    check("reset_sel", fwd_sel_r, 2'b00);
    check("reset_data", fwd_data_r, 64'h0);

    // Priority: st0 beats st2 on port 0; port 1 reads r0 against st1 writing r0.
    rd_en = 2'b11; rd_addr = {5'd0, 5'd5};
    clear_st();
    set_st(0, 1'b1, 1'b1, 5'd5, 32'hAAAA_0000);
    set_st(1, 1'b1, 1'b1, 5'd0, 32'h0000_DEAD);
    set_st(2, 1'b1, 1'b1, 5'd5, 32'h0000_1111);
    rst = 1'b1;
    step();
    check("prio_sel", fwd_sel_r, 2'b01);
    check("prio_data", fwd_data_r, {32'h0, 32'hAAAA_0000});
    check("prio_stall_req", stall_req, 1'b0);

    // Load-use: youngest hit not ready masks an older ready producer.
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    clear_st();
    set_st(0, 1'b1, 1'b0, 5'd7, 32'h0000_0077);
    set_st(1, 1'b1, 1'b1, 5'd7, 32'h0000_0099);
    stall = 6'b000100;
    #1;
    check("lu_stall_req_hi", stall_req, 1'b1);
    step();
    check("lu_hold_sel", fwd_sel_r, 2'b01);
    check("lu_hold_data", fwd_data_r, {32'h0, 32'hAAAA_0000});
    clear_st();
    set_st(1, 1'b1, 1'b1, 5'd7, 32'h0000_0055);
    #1;
    check("lu_stall_req_lo", stall_req, 1'b0);
    step();
    check("lu_cap_sel", fwd_sel_r, 2'b01);
    check("lu_cap_data", fwd_data_r, {32'h0, 32'h0000_0055});

    // Retention under stall after the producer leaves the window.
    stall = '0;
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    clear_st();
    set_st(2, 1'b1, 1'b1, 5'd9, 32'h0000_1234);
    step();
    check("ret_cap_sel", fwd_sel_r, 2'b10);
    check("ret_cap_data", fwd_data_r, {32'h0000_1234, 32'h0});
    clear_st();
    stall = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ret_hold_sel", fwd_sel_r, 2'b10);
      check("ret_hold_data", fwd_data_r, {32'h0000_1234, 32'h0});
    end
    stall = '0;
    step();
    check("ret_release_sel", fwd_sel_r, 2'b00);
    check("ret_release_data", fwd_data_r, 64'h0);

    // Flush wins over stall with active hits on both ports.
    rd_en = 2'b11; rd_addr = {5'd4, 5'd3};
    clear_st();
    set_st(0, 1'b1, 1'b1, 5'd3, 32'h0000_0033);
    set_st(1, 1'b1, 1'b1, 5'd4, 32'h0000_0044);
    step();
    check("two_port_sel", fwd_sel_r, 2'b11);
    check("two_port_data", fwd_data_r, {32'h0000_0044, 32'h0000_0033});
    flush = 1'b1; stall = 6'b000100;
    step();
    check("flush_sel", fwd_sel_r, 2'b00);
    check("flush_data", fwd_data_r, 64'h0);
    flush = 1'b0; stall = '0;
    step();
    check("refill_sel", fwd_sel_r, 2'b11);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_sel", fwd_sel_r, 2'b00);
    check("async_rst_data", fwd_data_r, 64'h0);
    rd_en = 2'b00;
    #1;
    check("no_ports_stall_req", stall_req, 1'b0);
    rst = 1'b1;
    clear_st();
    step();

    // 4x4 instance: for port p, stages p..3 write its register, stage p must win.
    for (int p = 0; p < 4; p++) begin
      b_rd_en = 4'b0001 << p;
      b_rd_addr = '0;
      b_rd_addr[p*5 +: 5] = 5'(10 + p);
      for (int s = 0; s < 4; s++) begin
        b_st_we[s]             = (s >= p);
        b_st_rdy[s]            = 1'b1;
        b_st_waddr[s*5 +: 5]   = 5'(10 + p);
        b_st_wdata[s*32 +: 32] = 32'hB000_0000 | (32'(p) << 8) | 32'(s);
      end
      step();
      check("p4_sel", b_sel, 4'b0001 << p);
      check("p4_data", b_data[p*32 +: 32], 32'hB000_0000 | (32'(p) << 8) | 32'(p));
      check("p4_stall_req", b_stall_req, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bypass_net.md
# bypass_net

Parametrised forwarding network for the decode stage. It compares NUM_RPORTS register-read addresses against NUM_STAGES in-flight producer stages and selects the youngest matching, ready producer for each port. It registers the select and data for use by the execute stage. It also raises a combinational load-use stall request when the youngest match is not yet ready, and keeps forwarded values across decode stalls. It replaces the fixed 2-port / 3-stage bypass in the ID→EX path.

## Interface
- NUM_RPORTS, 2, number of register read ports (≥1)
- NUM_STAGES, 3, number of producer stages; index 0 = youngest (EX), highest priority
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STALL_BIT, 2, bit of `stall` that freezes the decode stage
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  pipeline flush
- stall  in  6  StallBus; only bit STALL_BIT is used
- rd_en  in  NUM_RPORTS  per-port read enable
- rd_addr  in  NUM_RPORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- st_we  in  NUM_STAGES  per-stage write enable
- st_rdy  in  NUM_STAGES  per-stage data valid; 0 = load or multi-cycle result not yet available
- st_waddr  in  NUM_STAGES*ADDR_W  packed write addresses
- st_wdata  in  NUM_STAGES*DATA_W  packed write data
- fwd_sel_r  out  NUM_RPORTS  registered: use forwarded data for port p
- fwd_data_r  out  NUM_RPORTS*DATA_W  registered forwarded data
- stall_req  out  1  combinational load-use stall request

## Operation
- Match rule: `hit[p][s] = rd_en[p] & st_we[s] & (rd_addr[p] == st_waddr[s]) & (rd_addr[p] != 0)`. Register 0 is never forwarded.
- Winner per port: the lowest s with `hit[p][s]=1`. Older stages are ignored once a younger stage hits.
- Forwarding:
  - Winner ready (`st_rdy[s]=1`): next sel=1, next data = `st_wdata[s]`.
  - Winner not ready: `pend[p]=1`. No forward is produced for this port, and the data register is not updated.
  - No hit: next sel=0, next data=0.
- `stall_req = |pend`. Purely combinational, so control can freeze decode in the same cycle.
- Register update per port, in priority order:
  1. `rst=0`: sel=0, data=0.
  2. `flush=1`: sel=0, data=0. Flush wins over stall.
  3. `stall[STALL_BIT]=1`:
     - if a ready winner exists: capture it;
     - if `pend[p]`: retain the current value;
     - if no hit and sel_r=1: retain sel and data, so a producer that retires from the window during the stall is not lost;
     - if no hit and sel_r=0: stay 0.
  4. Otherwise: capture sel and data from the forwarding rule every cycle.
- Ports are independent. Two ports may select the same stage or different stages in the same cycle.
- Width rules: all compares are exactly ADDR_W bits. Data passes through unmodified. There is no arithmetic.

## Timing
- Reset values: fwd_sel_r=0, fwd_data_r=0. stall_req follows its inputs and is 0 when no ports are enabled.
- Latency:
  - Inputs to fwd_sel_r/fwd_data_r: 1 cycle, registered on the posedge of clk.
  - Inputs to stall_req: 0 cycles.
- Reset is asynchronous: asserting rst mid-cycle clears the outputs immediately. Deassertion takes effect at the next posedge.
- Flush in the same cycle as stall: the outputs clear.
- Unready producer that becomes ready while decode is stalled: at the next edge after `st_rdy` rises, sel=1 and data is captured. stall_req drops in the same cycle that `st_rdy` rises.
- Combinational path: `rd_addr`/`st_*` → `stall_req` only. No combinational path to fwd_*_r.

## Test plan
- Reset and priority:
  - Hold rst=0 with arbitrary inputs → fwd_sel_r=0, fwd_data_r=0.
  - Release reset with rd_addr[0]=5, st0 {we=1, waddr=5, wdata=0xAAAA0000}, st2 {we=1, waddr=5, wdata=0x1111} → next cycle sel[0]=1, data[0]=0xAAAA0000.
- Register zero: rd_addr[1]=0, st1 {we=1, waddr=0, wdata=0xDEAD} → sel[1]=0, data[1]=0.
- Load-use:
  - rd_addr[0]=7, st0 {we=1, rdy=0, waddr=7}, stall[2]=1 → stall_req=1 immediately, and the port's registers keep their prior value.
  - Next cycle the producer moves to st1 with rdy=1, wdata=0x55 → stall_req=0, and at the following edge sel[0]=1, data[0]=0x55.
- Retention under stall:
  - Capture 0x1234 for port 1 from st2.
  - Then drop all st_we with stall[2]=1 for 3 cycles → sel[1]=1, data[1]=0x1234 throughout.
  - Deassert stall → sel[1]=0 at the next edge.
- Flush priority: stall[2]=1 and flush=1 with active hits → both ports clear to sel=0, data=0 at the next edge.
- Async reset mid-operation: drop rst between clock edges while sel=1 → outputs go to 0 before the next posedge. Both ports with NUM_RPORTS=4 and NUM_STAGES=4 repeat the priority test on each port independently.
